vend_sequencer: RTL and testbench

//  Credit/vend/change controller for the coin vending machine. Accumulates c5/c10 coin pulses into credit,

---
 rtl/vm_pkg.sv | 31 +++
 rtl/vm_change_pacer.sv | 33 +++
 rtl/vend_sequencer.sv | 135 +++++++++++++
 tb/tb_vend_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vm_pkg : state encoding, coin values and price lookup for vending    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vm_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CREDIT = 2'd1;
   localparam logic [1:0] ST_VEND   = 2'd2;
   localparam logic [1:0] ST_CHANGE = 2'd3;

   localparam int V5  = 5;
   localparam int V10 = 10;

   function automatic int price_lookup(input logic [1:0] id,
                                       input int p0, input int p1,
                                       input int p2, input int p3);
      int r;
      r = p0;
      case (id)
         2'd1:    r = p1;
         2'd2:    r = p2;
         2'd3:    r = p3;
         default: r = p0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vm_change_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vm_change_pacer : alternating 5-unit change pulses, done on last one |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vm_change_pacer
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 7
) (
   input  logic                _clk,
   input  logic                _rst,
   input  logic                active,
   input  logic [CREDIT_W-1:0] credit,
   output logic                pulse,
   output logic                done
);

   localparam logic [CREDIT_W-1:0] c_V5 = CREDIT_W'(V5);

   logic r_gap;

   always_ff @(posedge _clk or posedge _rst) begin
      if (_rst)         r_gap <= 1'b0;
      else if (!active) r_gap <= 1'b0;
      else              r_gap <= pulse;
   end

   assign pulse = active && !r_gap && (credit >= c_V5);
   assign done  = active && ((credit < c_V5) || (pulse && (credit == c_V5)));

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_sequencer : credit / vend handshake / change controller         |
// | Optional inactivity refund when VM_TIMEOUT_EN is defined             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vend_sequencer #(
   parameter int CREDIT_W       = 7,
   parameter int MAX_CREDIT     = 60,
   parameter int PRICE0         = 15,
   parameter int PRICE1         = 20,
   parameter int PRICE2         = 25,
   parameter int PRICE3         = 40,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                _clk,
   input  logic                _rst,
   input  logic                c5,
   input  logic                c10,
   input  logic                sel_valid,
   input  logic [1:0]          sel_id,
   input  logic                cancel,
   input  logic                dispense_ready,
   output logic                vend_valid,
   output logic [1:0]          vend_id,
   output logic                change5,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          s
);
   import vm_pkg::*;

   localparam int c_SW = CREDIT_W + 1;

   logic [1:0]          r_state, w_next;
   logic [CREDIT_W-1:0] r_credit, w_remain;
   logic [1:0]          r_vend_id;
   logic                r_coin_reject;
   logic [c_SW-1:0]     w_coin_val, w_sum, w_price;
   logic                w_coin_any, w_coin_ok, w_sel_ok;
   logic                w_pulse, w_done, w_timeout;

   // A simultaneous c5/c10 pair is evaluated as one 15-unit event.
   always_comb begin
      w_coin_val = '0;
      if (c5)  w_coin_val = w_coin_val + c_SW'(V5);
      if (c10) w_coin_val = w_coin_val + c_SW'(V10);
   end

   assign w_coin_any = c5 | c10;
   assign w_coin_ok  = w_coin_any
                     && ((r_state == ST_IDLE) || (r_state == ST_CREDIT))
                     && (({1'b0, r_credit} + w_coin_val) <= c_SW'(MAX_CREDIT));
   assign w_sum      = {1'b0, r_credit} + (w_coin_ok ? w_coin_val : '0);
   assign w_price    = c_SW'(price_lookup(sel_id, PRICE0, PRICE1, PRICE2, PRICE3));
   assign w_sel_ok   = (r_state == ST_CREDIT) && sel_valid && (w_sum >= w_price);
   assign w_remain   = CREDIT_W'(w_sum - w_price);

   vm_change_pacer #(.CREDIT_W(CREDIT_W)) u_pacer (
      ._clk   (_clk),
      ._rst   (_rst),
      .active (r_state == ST_CHANGE),
      .credit (r_credit),
      .pulse  (w_pulse),
      .done   (w_done)
   );

`ifdef VM_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              w_activity;

   assign w_activity = w_coin_ok | sel_valid | cancel;

   always_ff @(posedge _clk or posedge _rst) begin
      if (_rst)                                      r_to_cnt <= '0;
      else if ((r_state != ST_CREDIT) || w_activity) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_CREDIT) && !w_activity
                    && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge _clk or posedge _rst) begin
      if (_rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_coin_ok) w_next = ST_CREDIT;
         ST_CREDIT: begin
            if (w_sel_ok)                w_next = ST_VEND;
            else if (cancel || w_timeout) w_next = ST_CHANGE;
         end
         ST_VEND:   if (dispense_ready) w_next = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
         ST_CHANGE: if (w_done) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge _clk or posedge _rst) begin
      if (_rst) begin
         r_credit      <= '0;
         r_vend_id     <= '0;
         r_coin_reject <= 1'b0;
      end else begin
         r_coin_reject <= w_coin_any & ~w_coin_ok;
         if (w_sel_ok) begin
            r_credit  <= w_remain;
            r_vend_id <= sel_id;
         end else if (w_coin_ok) begin
            r_credit <= w_sum[CREDIT_W-1:0];
         end else if (w_pulse) begin
            r_credit <= r_credit - CREDIT_W'(V5);
         end
      end
   end

   always_comb begin
      vend_valid  = (r_state == ST_VEND);
      vend_id     = r_vend_id;
      change5     = w_pulse;
      coin_reject = r_coin_reject;
      credit      = r_credit;
      s           = r_state;
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vend_sequencer : directed self-checking bench for vend_sequencer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vend_sequencer;

   logic       _clk = 1'b0;
   logic       _rst = 1'b1;
   logic       c5 = 1'b0, c10 = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
   logic       dispense_ready = 1'b0;
   logic [1:0] sel_id = 2'd0;
   logic       vend_valid, change5, coin_reject;
   logic [1:0] vend_id, s;
   logic [6:0] credit;

   int errors = 0;
   int checks = 0;

   vend_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      ._clk(_clk), ._rst(_rst), .c5(c5), .c10(c10), .sel_valid(sel_valid),
      .sel_id(sel_id), .cancel(cancel), .dispense_ready(dispense_ready),
      .vend_valid(vend_valid), .vend_id(vend_id), .change5(change5),
      .coin_reject(coin_reject), .credit(credit), .s(s)
   );

   always #5 _clk = ~_clk;

   task automatic tick();
      @(posedge _clk);
      #1;
   endtask

   task automatic coin(input logic a5, input logic a10);
      c5 = a5; c10 = a10;
      tick();
      c5 = 1'b0; c10 = 1'b0;
   endtask

   task automatic select(input logic [1:0] id);
      sel_valid = 1'b1; sel_id = id;
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic do_reset();
      _rst = 1'b1;
      tick();
      _rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      _rst = 1'b1;
      tick(); tick();
      checks++;
      if ({vend_valid, vend_id, change5, coin_reject, credit, s} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {vend_valid, vend_id, change5, coin_reject, credit, s});
      end
      _rst = 1'b0;
      tick();
      checks++;
      if (s !== 2'd0) begin errors++; $display("FAIL reset_idle: s=%0d expected 0", s); end
   endtask

   task automatic test_vend_exact();
      int n;
      coin(1'b0, 1'b1);
      coin(1'b1, 1'b0);
      checks++;
      if (credit !== 7'd15 || s !== 2'd1) begin
         errors++; $display("FAIL credit15: credit=%0d s=%0d expected 15/1", credit, s);
      end
      select(2'd0);
      checks++;
      if (vend_valid !== 1'b1 || vend_id !== 2'd0 || credit !== 7'd0 || s !== 2'd2) begin
         errors++;
         $display("FAIL vend0_start: valid=%0b id=%0d credit=%0d s=%0d expected 1/0/0/2",
                  vend_valid, vend_id, credit, s);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (vend_valid !== 1'b1 || s !== 2'd2) begin
         errors++; $display("FAIL vend0_hold: valid=%0b s=%0d expected 1/2", vend_valid, s);
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (change5) n++;
         tick();
      end
      checks++;
      if (vend_valid !== 1'b0 || s !== 2'd0 || credit !== 7'd0 || n !== 0) begin
         errors++;
         $display("FAIL vend0_done: valid=%0b s=%0d credit=%0d pulses=%0d expected 0/0/0/0",
                  vend_valid, s, credit, n);
      end
   endtask

   task automatic test_vend_change();
      int n;
      for (int i = 0; i < 3; i++) coin(1'b0, 1'b1);
      select(2'd2);
      checks++;
      if (vend_valid !== 1'b1 || vend_id !== 2'd2 || credit !== 7'd5) begin
         errors++;
         $display("FAIL vend2_start: valid=%0b id=%0d credit=%0d expected 1/2/5",
                  vend_valid, vend_id, credit);
      end
      c10 = 1'b1;
      tick();
      c10 = 1'b0;
      checks++;
      if (coin_reject !== 1'b1 || credit !== 7'd5) begin
         errors++;
         $display("FAIL vend_coin_reject: reject=%0b credit=%0d expected 1/5", coin_reject, credit);
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      checks++;
      if (s !== 2'd3 || vend_valid !== 1'b0) begin
         errors++; $display("FAIL vend2_to_change: s=%0d valid=%0b expected 3/0", s, vend_valid);
      end
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (change5) n++;
         tick();
      end
      checks++;
      if (n !== 1 || credit !== 7'd0 || s !== 2'd0) begin
         errors++;
         $display("FAIL vend2_change: pulses=%0d credit=%0d s=%0d expected 1/0/0", n, credit, s);
      end
   endtask

   task automatic test_ceiling();
      for (int i = 0; i < 6; i++) coin(1'b0, 1'b1);
      checks++;
      if (credit !== 7'd60) begin errors++; $display("FAIL credit60: got %0d expected 60", credit); end
      coin(1'b1, 1'b0);
      checks++;
      if (coin_reject !== 1'b1 || credit !== 7'd60) begin
         errors++; $display("FAIL ceil_reject: reject=%0b credit=%0d expected 1/60", coin_reject, credit);
      end
      tick();
      checks++;
      if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse: got %0b expected 0", coin_reject); end
      do_reset();
      for (int i = 0; i < 5; i++) coin(1'b0, 1'b1);
      coin(1'b1, 1'b1);
      checks++;
      if (coin_reject !== 1'b1 || credit !== 7'd50) begin
         errors++; $display("FAIL pair_reject: reject=%0b credit=%0d expected 1/50", coin_reject, credit);
      end
      coin(1'b0, 1'b1);
      checks++;
      if (coin_reject !== 1'b0 || credit !== 7'd60) begin
         errors++; $display("FAIL exact_ceiling: reject=%0b credit=%0d expected 0/60", coin_reject, credit);
      end
      do_reset();
   endtask

   task automatic test_coin_with_sel();
      coin(1'b0, 1'b1);
      c5 = 1'b1;
      select(2'd0);
      c5 = 1'b0;
      checks++;
      if (s !== 2'd2 || credit !== 7'd0 || vend_id !== 2'd0) begin
         errors++; $display("FAIL coin_then_sel: s=%0d credit=%0d id=%0d expected 2/0/0", s, credit, vend_id);
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
   endtask

   task automatic test_insufficient_cancel();
      int exp_c5[7]  = '{1, 0, 1, 0, 1, 0, 0};
      int exp_cr[7]  = '{15, 10, 10, 5, 5, 0, 0};
      int exp_st[7]  = '{3, 3, 3, 3, 3, 0, 0};
      coin(1'b0, 1'b1);
      coin(1'b1, 1'b0);
      select(2'd3);
      checks++;
      if (s !== 2'd1 || credit !== 7'd15 || vend_valid !== 1'b0) begin
         errors++;
         $display("FAIL sel_insufficient: s=%0d credit=%0d valid=%0b expected 1/15/0", s, credit, vend_valid);
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (change5 !== exp_c5[i][0] || credit !== exp_cr[i][6:0] || s !== exp_st[i][1:0]) begin
            errors++;
            $display("FAIL refund_cycle%0d: change5=%0b credit=%0d s=%0d expected %0d/%0d/%0d",
                     i, change5, credit, s, exp_c5[i], exp_cr[i], exp_st[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_in_change();
      int n;
      coin(1'b0, 1'b1);
      coin(1'b1, 1'b0);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      #2 _rst = 1'b1;
      #1;
      checks++;
      if ({vend_valid, vend_id, change5, coin_reject, credit, s} !== 13'd0) begin
         errors++;
         $display("FAIL async_reset: got %b expected 0",
                  {vend_valid, vend_id, change5, coin_reject, credit, s});
      end
      tick();
      _rst = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (change5) n++;
         tick();
      end
      checks++;
      if (n !== 0 || s !== 2'd0 || credit !== 7'd0) begin
         errors++; $display("FAIL post_reset: pulses=%0d s=%0d credit=%0d expected 0/0/0", n, s, credit);
      end
   endtask

   task automatic test_timeout();
      int n;
      coin(1'b0, 1'b1);
`ifdef VM_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (s !== 2'd1) begin errors++; $display("FAIL timeout_early: s=%0d expected 1", s); end
      tick();
      checks++;
      if (s !== 2'd3) begin errors++; $display("FAIL timeout_expire: s=%0d expected 3", s); end
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (change5) n++;
         tick();
      end
      checks++;
      if (n !== 2 || s !== 2'd0 || credit !== 7'd0) begin
         errors++; $display("FAIL timeout_refund: pulses=%0d s=%0d credit=%0d expected 2/0/0", n, s, credit);
      end
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (change5) n++;
         tick();
      end
      checks++;
      if (n !== 0 || s !== 2'd1 || credit !== 7'd10) begin
         errors++; $display("FAIL no_timeout: pulses=%0d s=%0d credit=%0d expected 0/1/10", n, s, credit);
      end
      do_reset();
`endif
   endtask

   initial begin
      test_reset();
      test_vend_exact();
      test_vend_change();
      test_ceiling();
      test_coin_with_sel();
      test_insufficient_cancel();
      test_reset_in_change();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
